// File: rtl/cvp14_pkg.sv
// Shared encodings and the width-parametrised saturation helper for the CVP14
// vector execution unit.
package cvp14_pkg;

    typedef enum logic [1:0] {
        OP_VADD = 2'b00,
        OP_VDOT = 2'b01,
        OP_SMUL = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Working width of the saturation helper; callers sign-extend into it.
    localparam int SAT_XW = 64;

    typedef struct packed {
        logic              ovf;
        logic              unf;
        logic [SAT_XW-1:0] val;
    } sat_t;

    // Clamp a signed value to the signed range of a w-bit word.
    function automatic sat_t sat(input logic signed [SAT_XW-1:0] x, input int unsigned w);
        logic signed [SAT_XW-1:0] hi;
        logic signed [SAT_XW-1:0] lo;
        sat_t                     r;
        hi    = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 32'd1));
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (x > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (x < lo) begin
            r.unf = 1'b1;
            r.val = lo;
        end else begin
            r.val = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/cvp_sat_lane.sv
// One element lane: saturating add or multiply of an element pair, plus the
// raw full-width product used by the dot-product accumulator.
module cvp_sat_lane
    import cvp14_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    input  logic                  mul_i,
    output logic [W-1:0]          res_o,
    output logic                  ovf_o,
    output logic                  unf_o,
    output logic signed [2*W-1:0] prod_o
);

    logic signed [W:0]        sum_s;
    logic signed [2*W-1:0]    prod_s;
    logic signed [SAT_XW-1:0] x_s;
    sat_t                     sr_s;
    logic                     unused_sat_hi_s;

    assign sum_s  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    assign prod_s = (2*W)'(a_i) * (2*W)'(b_i);

    // Select the operation result and clamp it to the element range.
    always_comb begin
        x_s  = mul_i ? SAT_XW'(prod_s) : SAT_XW'(sum_s);
        sr_s = sat(x_s, 32'(W));
    end

    assign res_o           = sr_s.val[W-1:0];
    assign ovf_o           = sr_s.ovf;
    assign unf_o           = sr_s.unf;
    assign prod_o          = prod_s;
    assign unused_sat_hi_s = ^sr_s.val[SAT_XW-1:W];

endmodule

// File: rtl/cvp_vector_exec.sv
// Multi-cycle saturating vector unit (VADD, VDOT, SMUL) processing LANES
// elements per cycle over VLEN-element operands latched at Start.
module cvp_vector_exec
    import cvp14_pkg::*;
#(
    parameter int W     = 16,
    parameter int VLEN  = 16,
    parameter int LANES = 4
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [W*VLEN-1:0] VecA,
    input  logic [W*VLEN-1:0] VecB,
    input  logic [W-1:0]      Scalar,
    output logic              Busy,
    output logic              Done,
    output logic [W*VLEN-1:0] Result,
    output logic [W-1:0]      DotOut,
    output logic              V,
    output logic              U
);

    localparam int N     = VLEN / LANES;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2*W + $clog2(VLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [W*VLEN-1:0]       a_q, a_d;
    logic [W*VLEN-1:0]       b_q, b_d;
    logic [W*VLEN-1:0]       result_q, result_d;
    logic [W-1:0]            scalar_q, scalar_d;
    logic [W-1:0]            dot_q, dot_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    v_q, v_d;
    logic                    u_q, u_d;
    logic                    busy_q;
    logic                    done_q;

    logic signed [W-1:0]     lane_a_s        [LANES];
    logic signed [W-1:0]     lane_b_s        [LANES];
    logic [W-1:0]            lane_res_s      [LANES];
    logic signed [2*W-1:0]   lane_prod_s     [LANES];
    logic signed [ACC_W-1:0] lane_prod_ext_s [LANES];
    logic [LANES-1:0]        lane_ovf_s;
    logic [LANES-1:0]        lane_unf_s;
    logic                    lane_mul_s;

    logic signed [ACC_W-1:0]  chunk_sum_s;
    logic signed [ACC_W-1:0]  dot_total_s;
    logic signed [SAT_XW-1:0] dot_ext_s;
    sat_t                     dot_sat_s;
    logic                     unused_dot_hi_s;

    assign lane_mul_s = (op_q == OP_SMUL) || (op_q == OP_VDOT);

    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        assign lane_a_s[l] = a_q[(int'(cnt_q) * LANES + l) * W +: W];
        assign lane_b_s[l] = (op_q == OP_SMUL) ? scalar_q
                                               : b_q[(int'(cnt_q) * LANES + l) * W +: W];
        assign lane_prod_ext_s[l] = {{(ACC_W - 2*W){lane_prod_s[l][2*W-1]}}, lane_prod_s[l]};

        cvp_sat_lane #(.W(W)) u_lane (
            .a_i    (lane_a_s[l]),
            .b_i    (lane_b_s[l]),
            .mul_i  (lane_mul_s),
            .res_o  (lane_res_s[l]),
            .ovf_o  (lane_ovf_s[l]),
            .unf_o  (lane_unf_s[l]),
            .prod_o (lane_prod_s[l])
        );
    end

    // Sum of this chunk's products; the accumulator is wide enough never to wrap.
    always_comb begin
        chunk_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            chunk_sum_s = chunk_sum_s + lane_prod_ext_s[i];
        end
    end

    assign dot_total_s     = acc_q + chunk_sum_s;
    assign dot_ext_s       = SAT_XW'(dot_total_s);
    assign dot_sat_s       = sat(dot_ext_s, 32'(W));
    assign unused_dot_hi_s = ^dot_sat_s.val[SAT_XW-1:W];

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        scalar_d = scalar_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        dot_d    = dot_q;
        v_d      = v_q;
        u_d      = u_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d     = op_e'(Op);
                    a_d      = VecA;
                    b_d      = VecB;
                    scalar_d = Scalar;
                    cnt_d    = '0;
                    acc_d    = '0;
                    v_d      = 1'b0;
                    u_d      = 1'b0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                // NOP spends no chunk cycles: DONE follows the accepting edge directly.
                if (op_q == OP_NOP) begin
                    state_d = DONE;
                end else begin
                    if (op_q == OP_VDOT) begin
                        acc_d = dot_total_s;
                        if (cnt_q == CNT_LAST) begin
                            dot_d = dot_sat_s.val[W-1:0];
                            v_d   = v_q | dot_sat_s.ovf;
                            u_d   = u_q | dot_sat_s.unf;
                        end else begin
                            dot_d = dot_q;
                        end
                    end else begin
                        for (int i = 0; i < LANES; i++) begin
                            result_d[(int'(cnt_q) * LANES + i) * W +: W] = lane_res_s[i];
                        end
                        v_d = v_q | (|lane_ovf_s);
                        u_d = u_q | (|lane_unf_s);
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and output registers; Reset aborts any operation at once.
    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            scalar_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            dot_q    <= '0;
            v_q      <= 1'b0;
            u_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            scalar_q <= scalar_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            dot_q    <= dot_d;
            v_q      <= v_d;
            u_q      <= u_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;
    assign DotOut = dot_q;
    assign V      = v_q;
    assign U      = u_q;

endmodule

// File: tb/tb_cvp_vector_exec.sv
// Scoreboard bench for cvp_vector_exec: directed operations push expected
// results; a Done-triggered monitor pops and compares them.
module tb_cvp_vector_exec;

    localparam int W  = 16;
    localparam int VL = 16;
    localparam int VW = W * VL;

    logic          Clk1;
    logic          Reset;
    logic          Start;
    logic [1:0]    Op;
    logic [VW-1:0] VecA;
    logic [VW-1:0] VecB;
    logic [W-1:0]  Scalar;
    logic          Busy;
    logic          Done;
    logic [VW-1:0] Result;
    logic [W-1:0]  DotOut;
    logic          V;
    logic          U;

    typedef struct {
        logic [VW-1:0] res;
        logic [W-1:0]  dot;
        logic          v;
        logic          u;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass    = 0;
    int   n_total   = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    cvp_vector_exec #(.W(W), .VLEN(VL), .LANES(4)) dut (
        .Clk1   (Clk1),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
        .VecA   (VecA),
        .VecB   (VecB),
        .Scalar (Scalar),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .DotOut (DotOut),
        .V      (V),
        .U      (U)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest pending expectation.
    always @(negedge Clk1) begin
        if (!Reset && Done === 1'b1) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got Done=1 required no pending op");
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", Result, mon_e.res);
                chk("dotout", VW'(DotOut), VW'(mon_e.dot));
                chk("flag_v", VW'(V), VW'(mon_e.v));
                chk("flag_u", VW'(U), VW'(mon_e.u));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [W-1:0] s, input logic [VW-1:0] er, input logic [W-1:0] ed,
                         input logic ev, input logic eu, input int lat, input bit pulse);
        exp_t e;
        int   k;
        @(negedge Clk1);
        chk("busy_idle", VW'(Busy), VW'(1'b0));
        Op = op; VecA = a; VecB = b; Scalar = s; Start = 1'b1;
        e.res = er; e.dot = ed; e.v = ev; e.u = eu;
        sb_q.push_back(e);
        done_exp++;
        @(posedge Clk1); #1;
        Start = 1'b0;
        chk("busy_rise", VW'(Busy), VW'(1'b1));
        k = 0;
        while (Done !== 1'b1 && k < 20) begin
            @(posedge Clk1); #1;
            k++;
            if (pulse && k == 1) begin
                Start = 1'b1; Op = 2'b10; Scalar = 16'h7fff;
            end else if (pulse && k == 2) begin
                Start = 1'b0;
            end
        end
        chk("done_latency", VW'(k), VW'(lat));
        @(posedge Clk1); #1;
        chk("busy_fall", VW'(Busy), VW'(1'b0));
        chk("done_fall", VW'(Done), VW'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   VW'(Busy),   '0);
        chk({tag, "_done"},   VW'(Done),   '0);
        chk({tag, "_result"}, Result,      '0);
        chk({tag, "_dotout"}, VW'(DotOut), '0);
        chk({tag, "_v"},      VW'(V),      '0);
        chk({tag, "_u"},      VW'(U),      '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] a, b, er, t2_res, t4_res;
        Reset = 1'b1; Start = 1'b0; Op = 2'b00;
        VecA = '0; VecB = '0; Scalar = '0;
        repeat (2) @(posedge Clk1);
        #1;
        check_all_zero("reset");
        @(negedge Clk1);
        Reset = 1'b0;

        // VADD a[i]=i, b[i]=100
        for (int i = 0; i < VL; i++) begin
            a[i*W +: W] = 16'(i); b[i*W +: W] = 16'd100; er[i*W +: W] = 16'(100 + i);
        end
        issue(2'b00, a, b, 16'h0000, er, 16'h0000, 1'b0, 1'b0, 4, 1'b0);

        // VADD saturating both ways
        a = '0; b = '0; er = '0;
        a[0 +: W]  = 16'h7fff; b[0 +: W]  = 16'h0001; er[0 +: W]  = 16'h7fff;
        a[W +: W]  = 16'h8000; b[W +: W]  = 16'hffff; er[W +: W]  = 16'h8000;
        t2_res = er;
        issue(2'b00, a, b, 16'h0000, er, 16'h0000, 1'b1, 1'b1, 4, 1'b0);

        // VDOT small, then VDOT saturating without wrap
        for (int i = 0; i < VL; i++) begin
            a[i*W +: W] = 16'd2; b[i*W +: W] = 16'd3;
        end
        issue(2'b01, a, b, 16'h0000, t2_res, 16'd96, 1'b0, 1'b0, 4, 1'b0);
        for (int i = 0; i < VL; i++) begin
            a[i*W +: W] = 16'h7fff; b[i*W +: W] = 16'h7fff;
        end
        issue(2'b01, a, b, 16'h0000, t2_res, 16'h7fff, 1'b1, 1'b0, 4, 1'b0);

        // SMUL by -2 with one element pushed past the negative limit
        b = '0;
        for (int i = 0; i < VL; i++) begin
            a[i*W +: W] = 16'(i); er[i*W +: W] = 16'(-2 * i);
        end
        a[5*W +: W] = 16'd20000; er[5*W +: W] = 16'h8000;
        t4_res = er;
        issue(2'b10, a, b, 16'hfffe, er, 16'h7fff, 1'b0, 1'b1, 4, 1'b0);

        // NOP: outputs held, flags cleared, Done one cycle after Start
        a = {VW{1'b1}}; b = {VW{1'b1}};
        issue(2'b11, a, b, 16'h1234, t4_res, 16'h7fff, 1'b0, 1'b0, 1, 1'b0);

        // VADD with a second Start pulsed during RUN, which must be ignored
        for (int i = 0; i < VL; i++) begin
            a[i*W +: W] = 16'(i); b[i*W +: W] = 16'(i); er[i*W +: W] = 16'(2 * i);
        end
        issue(2'b00, a, b, 16'h0000, er, 16'h7fff, 1'b0, 1'b0, 4, 1'b1);
        repeat (3) @(posedge Clk1);

        // Reset during RUN: everything clears at once and no Done follows
        @(negedge Clk1);
        for (int i = 0; i < VL; i++) begin
            a[i*W +: W] = 16'h7fff; b[i*W +: W] = 16'h0001;
        end
        Op = 2'b00; VecA = a; VecB = b; Start = 1'b1;
        @(posedge Clk1); #1;
        Start = 1'b0;
        repeat (2) @(posedge Clk1);
        #1;
        Reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge Clk1);
        Reset = 1'b0;
        repeat (6) @(posedge Clk1);

        // Fresh VADD after the abort
        for (int i = 0; i < VL; i++) begin
            a[i*W +: W] = 16'(i); b[i*W +: W] = 16'hfffb; er[i*W +: W] = 16'(i - 5);
        end
        issue(2'b00, a, b, 16'h0000, er, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
        repeat (3) @(posedge Clk1);

        chk("done_count", VW'(done_seen), VW'(done_exp));
        chk("scoreboard_empty", VW'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
